// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle ADD/SUB/ADC/SBC/AND/ORR/EOR with NZCV
// flags, plus a WIDTH-iteration shift-add multiplier behind the same interface.
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_ADC = 3'b100;
    localparam logic [2:0] OP_SBC = 3'b101;
    localparam logic [2:0] OP_EOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               arith;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   logic_res;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [3:0]         alu_flags;
    logic [WIDTH-1:0]   acc_add;

    // Single-cycle datapath: every arithmetic op is A + B' + cin in one adder.
    always_comb begin
        arith     = 1'b0;
        b_eff     = src_b;
        cin_eff   = 1'b0;
        logic_res = '0;
        case (op)
            OP_ADD: arith = 1'b1;
            OP_SUB: begin
                arith   = 1'b1;
                b_eff   = ~src_b;
                cin_eff = 1'b1;
            end
            OP_ADC: begin
                arith   = 1'b1;
                cin_eff = carry_in;
            end
            OP_SBC: begin
                arith   = 1'b1;
                b_eff   = ~src_b;
                cin_eff = carry_in;
            end
            OP_AND:  logic_res = src_a & src_b;
            OP_ORR:  logic_res = src_a | src_b;
            OP_EOR:  logic_res = src_a ^ src_b;
            default: logic_res = '0;
        endcase
        sum = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
        if (arith) begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (src_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != src_a[WIDTH-1]);
        end else begin
            alu_res = logic_res;
            alu_c   = 1'b0;
            alu_v   = 1'b0;
        end
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

    assign acc_add = acc_q + (b_q[0] ? a_q : '0);

    // Handshake: a word moves on a rising edge only when valid and ready are both
    // high; valid never depends on ready, and the requester holds its request
    // (and operands) until it sees in_ready, which is only sampled on that edge.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        in_ready    = reset & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
        accept      = in_valid & in_ready;

        case (state_q)
            S_MUL: begin
                acc_d = acc_add;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = acc_add;
                    flags_d     = {acc_add[WIDTH-1], (acc_add == '0), 2'b00};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
            end
        endcase

        // A new accept out of DONE overrides the drain back to IDLE above.
        if (accept) begin
            if (op == OP_MUL) begin
                acc_d       = '0;
                a_d         = src_a;
                b_d         = src_b;
                cnt_d       = CNT_W'(WIDTH);
                out_valid_d = 1'b0;
                state_d     = S_MUL;
            end else begin
                result_d    = alu_res;
                flags_d     = alu_flags;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign busy      = (state_q == S_MUL);
    assign state_dbg = state_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked multi-cycle ALU; next generation of the single-cycle datapath ALU.
- Adds carry-in ops (ADC/SBC), EOR, and an iterative shift-add multiplier.
- Uses valid/ready on input and output so the multi-cycle control path can stall on it.
- Sits between the decode/register-read stage and writeback; produces ARM-style NZCV flags.

Parameters:
- WIDTH, 32, datapath width in bits; legal values are 4 or more.
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 ADC, 101 SBC, 110 EOR, 111 MUL.
- carry_in  in  1  C flag input; used by ADC and SBC only.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flags  out  4  registered {N,Z,C,V}.
- busy  out  1  high while in the MUL state.

Behaviour:
- Handshake transfer rules:
  - Input accepted on a rising edge with in_valid & in_ready.
  - Output consumed on a rising edge with out_valid & out_ready.
- FSM states: IDLE, MUL, DONE.
- Reset (reset=0 at a clock edge) takes priority over everything:
  - state=IDLE; out_valid=0; result=0; flags=0; multiplier registers and counter=0.
  - Any in-flight operation, including a MUL part-way through, is discarded.
  - in_ready=0 while reset=0.
- in_ready = reset & (state==IDLE | (state==DONE & out_ready)).
  - This gives back-to-back throughput of 1/cycle for non-MUL ops.
- Arithmetic is computed as one (WIDTH+1)-bit sum, A + B' + cin:
  - ADD: B'=B, cin=0.
  - SUB: B'=~B, cin=1.
  - ADC: B'=B, cin=carry_in.
  - SBC: B'=~B, cin=carry_in.
- Flags for arithmetic ops:
  - C = sum bit WIDTH; for subtraction, C=1 means no borrow.
  - V = (A[MSB]==B'[MSB]) & (result[MSB]!=A[MSB]).
- Logic ops (AND/ORR/EOR) and MUL: C=0, V=0.
- All ops: N = result[WIDTH-1]; Z = (result==0).
- Non-MUL accept at edge 0:
  - result and flags registered on edge 0; state=DONE.
  - out_valid=1 from edge 0 onward (latency 1).
- MUL accept at edge 0:
  - Load acc=0, a_reg=src_a, b_reg=src_b, cnt=WIDTH; state=MUL; busy=1.
  - On each of edges 1..WIDTH: if b_reg[0], acc += a_reg; a_reg <<= 1; b_reg >>= 1; cnt--.
  - The update on the edge where cnt==1 writes result = low WIDTH bits of the new acc, sets flags, and moves to DONE.
  - out_valid=1 after edge WIDTH; latency WIDTH+1 cycles including the accept cycle.
  - MUL result is the product modulo 2^WIDTH; the same value for signed and unsigned operands.
- DONE state:
  - result and flags held stable while out_ready=0.
  - On out_ready=1 with no new accept: state=IDLE, out_valid=0.
  - On out_ready=1 with a simultaneous accept: the new op is handled exactly as from IDLE in the same edge, so out_valid stays 1 for a non-MUL op and drops to 0 for MUL.
- in_valid while in_ready=0 is ignored; the requester must hold the request. Operands are sampled only on the accept edge.
- result and flags change only on the completion edge or at reset; they never glitch in the MUL state.

Test Plan (WIDTH=32):
- Flags and result for single-cycle arithmetic (one cycle after accept):
  - ADD A=FFFFFFFF, B=00000001 -> result=00000000, flags=0110.
  - SUB A=80000000, B=00000001 -> result=7FFFFFFF, flags=0011.
  - ADC A=7FFFFFFF, B=0, carry_in=1 -> result=80000000, flags=1001.
  - SBC A=5, B=3, carry_in=0 -> result=00000001, flags=0010.
- MUL latency and busy:
  - A=00010003, B=00000005 -> out_valid exactly 32 edges after accept; result=0005000F; flags=0000; busy high for 32 cycles; in_ready=0 throughout.
- Backpressure on output: AND A=F0F0F0F0, B=FF00FF00 with out_ready=0 for 3 cycles -> result=F000F000 and flags=1000 held stable; in_ready=0; single transfer when out_ready rises.
- Back-to-back issue with out_ready=1:
  - Stream EOR(AAAAAAAA,FFFFFFFF), then ORR(0,0), then ADD(1,1) on consecutive cycles.
  - Expect one accept per cycle with out_valid continuously 1.
  - Results in order: 55555555 (flags 0000), 00000000 (flags 0100), 00000002 (flags 0000).
- Reset during MUL: drive reset=0 at MUL iteration 10 -> next edge out_valid=0, result=0, flags=0, state IDLE; after release, ADD(2,3) returns 00000005 with no stale data.
- Hold-off: in_valid high with changing operands while a MUL is in progress -> no extra transfer; only the operands present on the accept edge are used.
